// File: rtl/cnt_seq_checker.sv
// Sequence monitor for a free-running counter: tracks lock on the +1 modulo step,
// flags mismatches, stuck values and wraps, and keeps saturating statistics.
module cnt_seq_checker #(
  parameter int WIDTH       = 2,
  parameter int SYNC_LEN    = 2,
  parameter int STUCK_LIMIT = 4,
  parameter int STAT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              stuck,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [1:0]        state
);

  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int RW = $clog2(STUCK_LIMIT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [SW-1:0]    SYNC_TGT = SW'(SYNC_LEN);
  localparam logic [RW-1:0]    RUN_MAX  = RW'(STUCK_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == {STAT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + STAT_W'(1);
    end
  endfunction

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   prev_r, prev_s, expected_s;
  logic [SW-1:0]      sync_r, sync_s;
  logic [RW-1:0]      run_r, run_s, run_upd_s;
  logic               stuck_r, stuck_s;
  logic               err_pulse_r, err_pulse_s;
  logic               wrap_pulse_r, wrap_pulse_s;
  logic               locked_r;
  logic [STAT_W-1:0]  err_cnt_r, err_cnt_s;
  logic [STAT_W-1:0]  wrap_cnt_r, wrap_cnt_s;
  logic               match_s;

  // Next-state and next-datapath decode for one sample.
  always_comb begin
    state_s      = state_r;
    prev_s       = prev_r;
    sync_s       = sync_r;
    run_s        = run_r;
    stuck_s      = stuck_r;
    err_cnt_s    = err_cnt_r;
    wrap_cnt_s   = wrap_cnt_r;
    err_pulse_s  = 1'b0;
    wrap_pulse_s = 1'b0;
    expected_s   = prev_r + WIDTH'(1);
    match_s      = (cnt_in == expected_s);
    // A repeat extends the run (saturating); any new value restarts it at one.
    if (cnt_in == prev_r) begin
      run_upd_s = (run_r == RUN_MAX) ? run_r : run_r + RW'(1);
    end else begin
      run_upd_s = RW'(1);
    end

    if (clear) begin
      state_s    = ST_IDLE;
      prev_s     = '0;
      sync_s     = '0;
      run_s      = '0;
      stuck_s    = 1'b0;
      err_cnt_s  = '0;
      wrap_cnt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cnt_valid) begin
            prev_s  = cnt_in;
            sync_s  = '0;
            state_s = ST_SYNC;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SYNC: begin
          if (cnt_valid) begin
            prev_s  = cnt_in;
            run_s   = run_upd_s;
            stuck_s = (run_upd_s >= RUN_MAX);
            if (match_s) begin
              sync_s = sync_r + SW'(1);
              if (sync_s == SYNC_TGT) begin
                state_s = ST_LOCKED;
              end else begin
                state_s = ST_SYNC;
              end
            end else begin
              sync_s = '0;
            end
          end else begin
            state_s = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (cnt_valid) begin
            prev_s  = cnt_in;
            run_s   = run_upd_s;
            stuck_s = (run_upd_s >= RUN_MAX);
            if (match_s) begin
              if ((cnt_in == WIDTH'(0)) && (prev_r == CNT_MAX)) begin
                wrap_pulse_s = 1'b1;
                wrap_cnt_s   = sat_inc(wrap_cnt_r);
              end else begin
                wrap_pulse_s = 1'b0;
              end
            end else begin
              err_pulse_s = 1'b1;
              err_cnt_s   = sat_inc(err_cnt_r);
              sync_s      = '0;
              state_s     = ST_SYNC;
            end
          end else begin
            state_s = ST_LOCKED;
          end
        end
        default: begin
          state_s = ST_IDLE;
          prev_s  = '0;
          sync_s  = '0;
          run_s   = '0;
          stuck_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered output flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r       <= '0;
      sync_r       <= '0;
      run_r        <= '0;
      stuck_r      <= 1'b0;
      err_pulse_r  <= 1'b0;
      wrap_pulse_r <= 1'b0;
      locked_r     <= 1'b0;
      err_cnt_r    <= '0;
      wrap_cnt_r   <= '0;
    end else begin
      prev_r       <= prev_s;
      sync_r       <= sync_s;
      run_r        <= run_s;
      stuck_r      <= stuck_s;
      err_pulse_r  <= err_pulse_s;
      wrap_pulse_r <= wrap_pulse_s;
      locked_r     <= (state_s == ST_LOCKED);
      err_cnt_r    <= err_cnt_s;
      wrap_cnt_r   <= wrap_cnt_s;
    end
  end

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign stuck      = stuck_r;
  assign wrap_pulse = wrap_pulse_r;
  assign err_count  = err_cnt_r;
  assign wrap_count = wrap_cnt_r;
  assign state      = state_r;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: a rule-level model checked every cycle against
// two instances (8-bit and 2-bit statistics), plus literal spot checks.
module tb_cnt_seq_checker;
  localparam int SYNC_LEN = 2;
  localparam int STUCK    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] cnt_in = 2'd0;
  logic       cnt_valid = 1'b0;
  logic       clear = 1'b0;

  logic       locked8, errp8, stuck8, wrapp8;
  logic [7:0] errc8, wrapc8;
  logic [1:0] state8;
  logic       locked2, errp2, stuck2, wrapp2;
  logic [1:0] errc2, wrapc2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  cnt_seq_checker #(.WIDTH(2), .SYNC_LEN(SYNC_LEN), .STUCK_LIMIT(STUCK), .STAT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clear(clear),
    .locked(locked8), .err_pulse(errp8), .stuck(stuck8), .wrap_pulse(wrapp8),
    .err_count(errc8), .wrap_count(wrapc8), .state(state8));

  cnt_seq_checker #(.WIDTH(2), .SYNC_LEN(SYNC_LEN), .STUCK_LIMIT(STUCK), .STAT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clear(clear),
    .locked(locked2), .err_pulse(errp2), .stuck(stuck2), .wrap_pulse(wrapp2),
    .err_count(errc2), .wrap_count(wrapc2), .state(state2));

  always #5 clk = ~clk;

  // Model state: mode 0 idle, 1 hunting, 2 locked; statistics kept unbounded.
  int m_mode = 0, m_prev = 0, m_sync = 0, m_run = 0, m_s = 0, m_exp = 0;
  int m_stuck = 0, m_errp = 0, m_wrapp = 0, m_errs = 0, m_wraps = 0;

  // Behavioural model of the monitoring rules, one step per clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_prev = 0; m_sync = 0; m_run = 0;
      m_stuck = 0; m_errp = 0; m_wrapp = 0; m_errs = 0; m_wraps = 0;
    end else begin
      m_errp = 0;
      m_wrapp = 0;
      if (clear) begin
        m_mode = 0; m_prev = 0; m_sync = 0; m_run = 0;
        m_stuck = 0; m_errs = 0; m_wraps = 0;
      end else if (cnt_valid) begin
        m_s = int'(cnt_in);
        if (m_mode == 0) begin
          m_prev = m_s; m_sync = 0; m_mode = 1;
        end else begin
          m_exp = (m_prev + 1) % 4;
          if (m_s == m_prev) m_run = (m_run + 1 > STUCK) ? STUCK : m_run + 1;
          else m_run = 1;
          m_stuck = (m_run >= STUCK) ? 1 : 0;
          if (m_mode == 1) begin
            if (m_s == m_exp) begin
              m_sync = m_sync + 1;
              if (m_sync == SYNC_LEN) m_mode = 2;
            end else m_sync = 0;
          end else if (m_s != m_exp) begin
            m_errp = 1; m_errs = m_errs + 1; m_mode = 1; m_sync = 0;
          end else if (m_s == 0 && m_prev == 3) begin
            m_wrapp = 1; m_wraps = m_wraps + 1;
          end
          m_prev = m_s;
        end
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    chk("state8", 32'(state8), 32'(m_mode));
    chk("locked8", 32'(locked8), 32'(m_mode == 2));
    chk("errp8", 32'(errp8), 32'(m_errp));
    chk("wrapp8", 32'(wrapp8), 32'(m_wrapp));
    chk("stuck8", 32'(stuck8), 32'(m_stuck));
    chk("errc8", 32'(errc8), 32'(sat(m_errs, 255)));
    chk("wrapc8", 32'(wrapc8), 32'(sat(m_wraps, 255)));
    chk("state2", 32'(state2), 32'(m_mode));
    chk("errp2", 32'(errp2), 32'(m_errp));
    chk("errc2", 32'(errc2), 32'(sat(m_errs, 3)));
    chk("wrapc2", 32'(wrapc2), 32'(sat(m_wraps, 3)));
  end

  task automatic feed(input logic v, input logic [1:0] d, input logic c);
    cnt_valid = v;
    cnt_in    = d;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clean_lock_and_wrap();
    feed(1'b1, 2'd0, 1'b0); chk("lit_state_sync", 32'(state8), 32'd1);
    feed(1'b1, 2'd1, 1'b0); chk("lit_state_sync2", 32'(state8), 32'd1);
    feed(1'b1, 2'd2, 1'b0); chk("lit_locked", 32'(locked8), 32'd1);
    feed(1'b1, 2'd3, 1'b0); chk("lit_no_wrap_yet", 32'(wrapp8), 32'd0);
    feed(1'b1, 2'd0, 1'b0); chk("lit_wrap_pulse", 32'(wrapp8), 32'd1);
    chk("lit_wrap_count", 32'(wrapc8), 32'd1);
    chk("lit_err_count0", 32'(errc8), 32'd0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_state", 32'(state8), 32'd0);
    chk("lit_reset_locked", 32'(locked8), 32'd0);
    reset_n = 1'b1;

    clean_lock_and_wrap();

    // Mismatch while locked, then relock.
    feed(1'b1, 2'd1, 1'b0); chk("lit_wrap_one_cycle", 32'(wrapp8), 32'd0);
    feed(1'b1, 2'd2, 1'b0);
    feed(1'b1, 2'd0, 1'b0);
    chk("lit_err_pulse", 32'(errp8), 32'd1);
    chk("lit_err_count1", 32'(errc8), 32'd1);
    chk("lit_unlocked", 32'(locked8), 32'd0);
    chk("lit_state_resync", 32'(state8), 32'd1);
    feed(1'b1, 2'd1, 1'b0); chk("lit_err_one_cycle", 32'(errp8), 32'd0);
    feed(1'b1, 2'd2, 1'b0); chk("lit_relocked", 32'(locked8), 32'd1);

    // Stuck value entered from LOCKED.
    feed(1'b1, 2'd3, 1'b0);
    feed(1'b1, 2'd0, 1'b0);
    feed(1'b1, 2'd1, 1'b0);
    feed(1'b1, 2'd2, 1'b0);
    feed(1'b1, 2'd2, 1'b0); chk("lit_stuck_err_count", 32'(errc8), 32'd2);
    feed(1'b1, 2'd2, 1'b0); chk("lit_stuck_not_yet", 32'(stuck8), 32'd0);
    feed(1'b1, 2'd2, 1'b0); chk("lit_stuck_set", 32'(stuck8), 32'd1);
    feed(1'b1, 2'd3, 1'b0); chk("lit_stuck_clear", 32'(stuck8), 32'd0);
    chk("lit_stuck_err_once", 32'(errc8), 32'd2);
    feed(1'b1, 2'd0, 1'b0); chk("lit_locked_err2", 32'(locked8), 32'd1);

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1;
    chk("lit_async_state", 32'(state8), 32'd0);
    chk("lit_async_locked", 32'(locked8), 32'd0);
    chk("lit_async_errc", 32'(errc8), 32'd0);
    chk("lit_async_wrapc", 32'(wrapc8), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    clean_lock_and_wrap();

    // Valid gap while locked, then clear against a mismatching sample.
    for (int i = 0; i < 10; i++) feed(1'b0, 2'd3, 1'b0);
    chk("lit_gap_locked", 32'(locked8), 32'd1);
    chk("lit_gap_wrapc", 32'(wrapc8), 32'd1);
    feed(1'b1, 2'd3, 1'b1);
    chk("lit_clear_state", 32'(state8), 32'd0);
    chk("lit_clear_errp", 32'(errp8), 32'd0);
    chk("lit_clear_wrapc", 32'(wrapc8), 32'd0);
    feed(1'b0, 2'd0, 1'b0);

    // Five lock/break cycles to saturate the 2-bit statistics.
    feed(1'b1, 2'd0, 1'b0);
    feed(1'b1, 2'd1, 1'b0);
    feed(1'b1, 2'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      feed(1'b1, 2'd0, 1'b0); chk("lit_sat_errp", 32'(errp2), 32'd1);
      feed(1'b1, 2'd1, 1'b0);
      feed(1'b1, 2'd2, 1'b0);
    end
    chk("lit_sat_errc2", 32'(errc2), 32'd3);
    chk("lit_sat_errc8", 32'(errc8), 32'd5);
    feed(1'b0, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
